// File: rtl/cfr_peak_alloc.sv
// Peak allocator: qualifies peak-detector output against the clipping threshold and
// dispatches each excess pulse to the lowest-index free CPG, tracking busy windows and stats.
module cfr_peak_alloc #(
    parameter int DATA_WIDTH = 16,
    parameter int ITERATIONS = 7,
    parameter int NUM_CPG    = 4,
    parameter int PULSE_LEN  = 64,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH:0]   peak_r,
    input  logic [ITERATIONS:0]   peak_theta,
    input  logic                  peak_phase,
    input  logic                  peak_valid,
    input  logic                  ctrl_enable,
    input  logic [DATA_WIDTH:0]   ctrl_clipping_threshold,
    input  logic                  stat_clear,
    output logic [NUM_CPG-1:0]    cpg_start,
    output logic [DATA_WIDTH:0]   cpg_scale,
    output logic [ITERATIONS:0]   cpg_theta,
    output logic                  cpg_phase,
    output logic [NUM_CPG-1:0]    cpg_busy,
    output logic [CNT_WIDTH-1:0]  stat_peaks,
    output logic [CNT_WIDTH-1:0]  stat_drops
);

    localparam int                   BW      = $clog2(PULSE_LEN + 1);
    localparam logic [BW-1:0]        RELOAD  = BW'(PULSE_LEN);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic                  s1_valid_q,  s1_valid_d;
    logic [DATA_WIDTH:0]   s1_excess_q, s1_excess_d;
    logic [ITERATIONS:0]   s1_theta_q,  s1_theta_d;
    logic                  s1_phase_q,  s1_phase_d;

    logic [BW-1:0]         cnt_q [NUM_CPG];
    logic [BW-1:0]         cnt_d [NUM_CPG];
    logic [NUM_CPG-1:0]    start_q, start_d;
    logic [NUM_CPG-1:0]    busy_q,  busy_d;
    logic [DATA_WIDTH:0]   scale_q, scale_d;
    logic [ITERATIONS:0]   theta_q, theta_d;
    logic                  phase_q, phase_d;
    logic [CNT_WIDTH-1:0]  peaks_q, peaks_d;
    logic [CNT_WIDTH-1:0]  drops_q, drops_d;
    logic                  alloc_found;

    // Excess is only meaningful when qualified, where peak_r > threshold rules out wrap.
    always_comb begin
        s1_valid_d  = peak_valid & ctrl_enable & (peak_r > ctrl_clipping_threshold);
        s1_excess_d = peak_r - ctrl_clipping_threshold;
        s1_theta_d  = peak_theta;
        s1_phase_d  = peak_phase;
    end

    // A CPG whose counter reads 1 finishes this cycle, so it can be reloaded without a gap.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
        start_d     = '0;
        scale_d     = '0;
        theta_d     = '0;
        phase_d     = 1'b0;
        alloc_found = 1'b0;
        for (int k = 0; k < NUM_CPG; k++) begin
            cnt_d[k] = (cnt_q[k] != '0) ? cnt_q[k] - BW'(1) : '0;
            if (s1_valid_q && !alloc_found && (cnt_q[k] <= BW'(1))) begin
                alloc_found = 1'b1;
                start_d[k]  = 1'b1;
                cnt_d[k]    = RELOAD;
            end
        end
        if (alloc_found) begin
            scale_d = s1_excess_q;
            theta_d = s1_theta_q;
            phase_d = s1_phase_q;
        end
        for (int k = 0; k < NUM_CPG; k++) begin
            busy_d[k] = (cnt_d[k] != '0);
        end

        peaks_d = peaks_q;
        drops_d = drops_q;
        if (stat_clear) begin
            peaks_d = '0;
            drops_d = '0;
        end else if (s1_valid_q) begin
            if (peaks_q != CNT_MAX) peaks_d = peaks_q + CNT_WIDTH'(1);
            if (!alloc_found && (drops_q != CNT_MAX)) drops_d = drops_q + CNT_WIDTH'(1);
        end
    end

    // NOTE: state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_excess_q <= '0;
            s1_theta_q  <= '0;
            s1_phase_q  <= 1'b0;
            start_q     <= '0;
            busy_q      <= '0;
            scale_q     <= '0;
            theta_q     <= '0;
            phase_q     <= 1'b0;
            peaks_q     <= '0;
            drops_q     <= '0;
            // NOTE: the busy counters are cleared on reset so any in-flight pulse is abandoned.
            for (int k = 0; k < NUM_CPG; k++) cnt_q[k] <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_excess_q <= s1_excess_d;
            s1_theta_q  <= s1_theta_d;
            s1_phase_q  <= s1_phase_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            scale_q     <= scale_d;
            theta_q     <= theta_d;
            phase_q     <= phase_d;
            peaks_q     <= peaks_d;
            drops_q     <= drops_d;
            for (int k = 0; k < NUM_CPG; k++) cnt_q[k] <= cnt_d[k];
        end
    end

    assign cpg_start  = start_q;
    assign cpg_scale  = scale_q;
    assign cpg_theta  = theta_q;
    assign cpg_phase  = phase_q;
    assign cpg_busy   = busy_q;
    assign stat_peaks = peaks_q;
    assign stat_drops = drops_q;

endmodule

// File: tb/tb_cfr_peak_alloc.sv
// Bench for cfr_peak_alloc: directed scenarios plus randomized traffic against a
// time-based model (each CPG tracked by the edge at which it becomes free).
module tb_cfr_peak_alloc;

    localparam int DW   = 16;
    localparam int IT   = 7;
    localparam int NC   = 4;
    localparam int PL   = 64;
    localparam int CW   = 8;
    localparam int MAXC = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DW:0]       peak_r = '0;
    logic [IT:0]       peak_theta = '0;
    logic              peak_phase = 1'b0;
    logic              peak_valid = 1'b0;
    logic              ctrl_enable = 1'b1;
    logic [DW:0]       ctrl_clipping_threshold = 17'd1000;
    logic              stat_clear = 1'b0;
    logic [NC-1:0]     cpg_start;
    logic [DW:0]       cpg_scale;
    logic [IT:0]       cpg_theta;
    logic              cpg_phase;
    logic [NC-1:0]     cpg_busy;
    logic [CW-1:0]     stat_peaks;
    logic [CW-1:0]     stat_drops;

    int n_vec = 0;
    int n_err = 0;

    cfr_peak_alloc #(
        .DATA_WIDTH(DW), .ITERATIONS(IT), .NUM_CPG(NC), .PULSE_LEN(PL), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .peak_r(peak_r), .peak_theta(peak_theta), .peak_phase(peak_phase), .peak_valid(peak_valid),
        .ctrl_enable(ctrl_enable), .ctrl_clipping_threshold(ctrl_clipping_threshold),
        .stat_clear(stat_clear),
        .cpg_start(cpg_start), .cpg_scale(cpg_scale), .cpg_theta(cpg_theta), .cpg_phase(cpg_phase),
        .cpg_busy(cpg_busy), .stat_peaks(stat_peaks), .stat_drops(stat_drops)
    );

    always #5 clk = ~clk;

    // Model: a peak sampled at edge n is dispatched at edge n+1; a CPG started at edge s
    // is busy after edges s..s+PL-1 and may be started again at edge s+PL.
    int          edge_n = 0;
    int          free_at [NC];
    logic        m_pend;
    logic [DW:0] m_exc;
    logic [IT:0] m_th;
    logic        m_ph;
    logic [NC-1:0] e_start, e_busy;
    logic [DW:0]   e_scale;
    logic [IT:0]   e_theta;
    logic          e_phase;
    int            e_peaks, e_drops;

    task automatic model_reset();
        for (int i = 0; i < NC; i++) free_at[i] = 0;
        m_pend = 1'b0; m_exc = '0; m_th = '0; m_ph = 1'b0;
        e_start = '0; e_busy = '0; e_scale = '0; e_theta = '0; e_phase = 1'b0;
        e_peaks = 0; e_drops = 0;
    endtask

    task automatic model_edge(input logic pv, input logic [DW:0] r, input logic [IT:0] th, input logic ph);
        int k;
        edge_n++;
        k = -1;
        e_start = '0; e_scale = '0; e_theta = '0; e_phase = 1'b0;
        if (m_pend) begin
            for (int i = NC - 1; i >= 0; i--) if (free_at[i] <= edge_n) k = i;
            if (k >= 0) begin
                e_start[k] = 1'b1;
                e_scale = m_exc; e_theta = m_th; e_phase = m_ph;
                free_at[k] = edge_n + PL;
            end
        end
        if (stat_clear) begin
            e_peaks = 0; e_drops = 0;
        end else if (m_pend) begin
            if (e_peaks < MAXC) e_peaks++;
            if (k < 0 && e_drops < MAXC) e_drops++;
        end
        for (int i = 0; i < NC; i++) e_busy[i] = (edge_n < free_at[i]);
        m_pend = pv && ctrl_enable && (r > ctrl_clipping_threshold);
        m_exc  = r - ctrl_clipping_threshold;
        m_th   = th;
        m_ph   = ph;
    endtask

    task automatic step(input logic pv, input logic [DW:0] r, input logic [IT:0] th, input logic ph);
        peak_valid = pv; peak_r = r; peak_theta = th; peak_phase = ph;
        @(posedge clk);
        model_edge(pv, r, th, ph);
        #1;
        peak_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, '0, '0, 1'b0);
    endtask

    task automatic test_reset();
        #1;
        n_vec++; if (cpg_busy !== '0 || cpg_start !== '0) begin
            $display("FAIL reset_in: busy=%b start=%b expected 0000/0000", cpg_busy, cpg_start); n_err++; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        n_vec++; if (stat_peaks !== '0 || stat_drops !== '0 || cpg_scale !== '0) begin
            $display("FAIL reset_stats: peaks=%0d drops=%0d scale=%0d expected 0", stat_peaks, stat_drops, cpg_scale); n_err++; end
    endtask

    task automatic test_single();
        int busy_cycles;
        ctrl_clipping_threshold = 17'd1000;
        step(1'b1, 17'd1500, 8'h5A, 1'b1);
        n_vec++; if (cpg_start !== 4'b0000) begin
            $display("FAIL single_early: start=%b expected 0000", cpg_start); n_err++; end
        step(1'b0, '0, '0, 1'b0);
        n_vec++; if (cpg_start !== 4'b0001) begin
            $display("FAIL single_start: start=%b expected 0001", cpg_start); n_err++; end
        n_vec++; if (cpg_scale !== 17'd500 || cpg_theta !== 8'h5A || cpg_phase !== 1'b1) begin
            $display("FAIL single_data: scale=%0d theta=%h phase=%b expected 500/5a/1", cpg_scale, cpg_theta, cpg_phase); n_err++; end
        busy_cycles = 0;
        for (int i = 0; i < 100; i++) begin
            if (cpg_busy[0]) busy_cycles++;
            step(1'b0, '0, '0, 1'b0);
        end
        n_vec++; if (busy_cycles != PL) begin
            $display("FAIL single_busy_len: %0d cycles expected %0d", busy_cycles, PL); n_err++; end
        n_vec++; if (stat_peaks !== 8'd1 || stat_drops !== 8'd0) begin
            $display("FAIL single_stats: peaks=%0d drops=%0d expected 1/0", stat_peaks, stat_drops); n_err++; end
    endtask

    task automatic test_pool_drop();
        logic [NC-1:0] seen [$];
        stat_clear = 1'b1; idle(1); stat_clear = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 17'd2000, 8'(i), 1'b0);
            if (cpg_start != '0) seen.push_back(cpg_start);
            step(1'b0, '0, '0, 1'b0);
            if (cpg_start != '0) seen.push_back(cpg_start);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, '0, 1'b0);
            if (cpg_start != '0) seen.push_back(cpg_start);
        end
        n_vec++; if (seen.size() != 4) begin
            $display("FAIL pool_count: %0d starts expected 4", seen.size()); n_err++; end
        else begin
            for (int i = 0; i < 4; i++) begin
                n_vec++; if (seen[i] !== NC'(1 << i)) begin
                    $display("FAIL pool_order[%0d]: start=%b expected %b", i, seen[i], NC'(1 << i)); n_err++; end
            end
        end
        n_vec++; if (stat_peaks !== 8'd6 || stat_drops !== 8'd2) begin
            $display("FAIL pool_stats: peaks=%0d drops=%0d expected 6/2", stat_peaks, stat_drops); n_err++; end
        idle(70);
    endtask

    task automatic test_back_to_back();
        int first, last, cnt, other;
        int starts0;
        stat_clear = 1'b1; idle(1); stat_clear = 1'b0;
        first = -1; last = -1; cnt = 0; other = 0; starts0 = 0;
        for (int j = 0; j < 200; j++) begin
            step((j == 0) || (j == 64), 17'd2000, 8'h11, 1'b0);
            if (cpg_busy[0]) begin
                if (first < 0) first = j;
                last = j; cnt++;
            end
            if (cpg_busy[NC-1:1] != '0) other++;
            if (cpg_start == 4'b0001) starts0++;
        end
        n_vec++; if (cnt != 2 * PL || (last - first + 1) != 2 * PL) begin
            $display("FAIL b2b_busy: %0d cycles span %0d expected %0d continuous", cnt, last - first + 1, 2 * PL); n_err++; end
        n_vec++; if (starts0 != 2 || other != 0) begin
            $display("FAIL b2b_alloc: cpg0 starts=%0d other busy=%0d expected 2/0", starts0, other); n_err++; end
        n_vec++; if (stat_drops !== 8'd0 || stat_peaks !== 8'd2) begin
            $display("FAIL b2b_stats: peaks=%0d drops=%0d expected 2/0", stat_peaks, stat_drops); n_err++; end
    endtask

    task automatic test_no_qualify();
        int starts;
        stat_clear = 1'b1; idle(1); stat_clear = 1'b0;
        ctrl_clipping_threshold = 17'd1000;
        starts = 0;
        step(1'b1, 17'd1000, 8'h01, 1'b0); if (cpg_start != '0) starts++;
        step(1'b1, 17'd999,  8'h02, 1'b0); if (cpg_start != '0) starts++;
        ctrl_enable = 1'b0;
        step(1'b1, 17'd5000, 8'h03, 1'b0); if (cpg_start != '0) starts++;
        ctrl_enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, '0, 1'b0); if (cpg_start != '0) starts++;
        end
        n_vec++; if (starts != 0) begin
            $display("FAIL noq_start: %0d starts expected 0", starts); n_err++; end
        n_vec++; if (stat_peaks !== 8'd0 || stat_drops !== 8'd0) begin
            $display("FAIL noq_stats: peaks=%0d drops=%0d expected 0/0", stat_peaks, stat_drops); n_err++; end
        step(1'b1, 17'd1001, 8'h04, 1'b1);
        step(1'b0, '0, '0, 1'b0);
        n_vec++; if (cpg_start !== 4'b0001 || cpg_scale !== 17'd1) begin
            $display("FAIL noq_edge: start=%b scale=%0d expected 0001/1", cpg_start, cpg_scale); n_err++; end
        idle(70);
    endtask

    task automatic test_async_reset();
        step(1'b1, 17'd2000, 8'h22, 1'b0);
        idle(11);
        n_vec++; if (cpg_busy[0] !== 1'b1) begin
            $display("FAIL arst_pre: busy0=%b expected 1", cpg_busy[0]); n_err++; end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (cpg_busy !== '0 || cpg_start !== '0 || stat_peaks !== '0 || stat_drops !== '0) begin
            $display("FAIL arst_now: busy=%b start=%b peaks=%0d drops=%0d expected 0", cpg_busy, cpg_start, stat_peaks, stat_drops); n_err++; end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(1'b1, 17'd1800, 8'h33, 1'b1);
        step(1'b0, '0, '0, 1'b0);
        n_vec++; if (cpg_start !== 4'b0001 || cpg_scale !== 17'd800) begin
            $display("FAIL arst_after: start=%b scale=%0d expected 0001/800", cpg_start, cpg_scale); n_err++; end
    endtask

    task automatic test_saturation();
        stat_clear = 1'b1; idle(1); stat_clear = 1'b0;
        for (int i = 0; i < 400; i++) step(1'b1, 17'd3000, 8'(i), 1'b0);
        n_vec++; if (stat_drops !== 8'hFF || stat_peaks !== 8'hFF) begin
            $display("FAIL sat_level: peaks=%h drops=%h expected ff/ff", stat_peaks, stat_drops); n_err++; end
        step(1'b1, 17'd3000, 8'h44, 1'b0);
        n_vec++; if (stat_drops !== 8'hFF) begin
            $display("FAIL sat_hold: drops=%h expected ff", stat_drops); n_err++; end
        stat_clear = 1'b1;
        step(1'b1, 17'd3000, 8'h55, 1'b0);
        stat_clear = 1'b0;
        n_vec++; if (stat_drops !== 8'h00 || stat_peaks !== 8'h00) begin
            $display("FAIL sat_clear: peaks=%h drops=%h expected 00/00", stat_peaks, stat_drops); n_err++; end
    endtask

    task automatic test_random();
        logic          pv, ph;
        logic [DW:0]   r;
        logic [IT:0]   th;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 49) == 0) ctrl_clipping_threshold = (DW + 1)'($urandom_range(500, 2500));
            ctrl_enable = ($urandom_range(0, 15) != 0);
            stat_clear  = ($urandom_range(0, 199) == 0);
            pv = ($urandom_range(0, 2) == 0);
            r  = (DW + 1)'($urandom_range(0, 4000));
            th = (IT + 1)'($urandom);
            ph = 1'($urandom);
            step(pv, r, th, ph);
            n_vec++; if (cpg_start !== e_start) begin
                $display("FAIL rnd_start@%0d: got %b expected %b", i, cpg_start, e_start); n_err++; end
            n_vec++; if (cpg_scale !== e_scale || cpg_theta !== e_theta || cpg_phase !== e_phase) begin
                $display("FAIL rnd_data@%0d: got %0d/%h/%b expected %0d/%h/%b", i, cpg_scale, cpg_theta, cpg_phase, e_scale, e_theta, e_phase); n_err++; end
            n_vec++; if (cpg_busy !== e_busy) begin
                $display("FAIL rnd_busy@%0d: got %b expected %b", i, cpg_busy, e_busy); n_err++; end
            n_vec++; if (stat_peaks !== e_peaks[CW-1:0] || stat_drops !== e_drops[CW-1:0]) begin
                $display("FAIL rnd_stats@%0d: got %0d/%0d expected %0d/%0d", i, stat_peaks, stat_drops, e_peaks, e_drops); n_err++; end
        end
        stat_clear = 1'b0;
        ctrl_enable = 1'b1;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_pool_drop();
        test_back_to_back();
        test_no_qualify();
        test_async_reset();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
